reg_wb_arbiter: RTL

Shares the single write port of the 8x8-bit register file between two writeback sources: the ALU result path and the data-memory load path. Each source hands off through a one-entry holding slot with a valid/ready handshake. A fixed-priority arbiter with a starvation guard drains the slots onto the register file's WRITE/INADDRESS/IN inputs. A per-register pending mask is exported for hazard/stall logic in the CPU control unit.

---
 rtl/reg_wb_pkg.sv | 20 ++
 rtl/wb_slot.sv | 38 +++
 rtl/reg_wb_arbiter.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/reg_wb_pkg.sv
// Shared widths, source ids and slot payload type for the register-file writeback arbiter.
package reg_wb_pkg;

    localparam int unsigned DATA_W   = 8;
    localparam int unsigned ADDR_W   = 3;
    localparam int unsigned NUM_REGS = 2 ** ADDR_W;
    localparam int unsigned CNT_W    = 16;

    typedef enum logic {
        WB_ALU = 1'b0,
        WB_MEM = 1'b1
    } wb_port_e;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_slot_t;

endpackage

// File: rtl/wb_slot.sv
// One-entry writeback holding slot: accepts on valid/ready, empties when the arbiter drains it.
module wb_slot #(
    parameter int unsigned DATA_W = reg_wb_pkg::DATA_W,
    parameter int unsigned ADDR_W = reg_wb_pkg::ADDR_W
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              in_valid,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_data,
    input  logic              drain,
    output logic              ready_c,
    output logic              valid,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data
);

    logic accept_c;

    // A slot being drained this cycle can take a new entry on the same edge.
    assign ready_c  = !RESET && (!valid || drain);
    assign accept_c = in_valid && ready_c;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            valid <= 1'b0;
            addr  <= '0;
            data  <= '0;
        end else if (accept_c) begin
            valid <= 1'b1;
            addr  <= in_addr;
            data  <= in_data;
        end else if (drain) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/reg_wb_arbiter.sv
// Arbitrates ALU and load writebacks onto the single register-file write port.
// Optional REG_WB_STATS_EN adds saturating per-source grant counters.
module reg_wb_arbiter #(
    parameter int unsigned DATA_W   = reg_wb_pkg::DATA_W,
    parameter int unsigned ADDR_W   = reg_wb_pkg::ADDR_W,
    parameter int unsigned MAX_WAIT = 3
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    ALU_VALID,
    output logic                    ALU_READY,
    input  logic [ADDR_W-1:0]       ALU_ADDR,
    input  logic [DATA_W-1:0]       ALU_DATA,
    input  logic                    MEM_VALID,
    output logic                    MEM_READY,
    input  logic [ADDR_W-1:0]       MEM_ADDR,
    input  logic [DATA_W-1:0]       MEM_DATA,
    output logic                    RF_WRITE,
    output logic [ADDR_W-1:0]       RF_INADDRESS,
    output logic [DATA_W-1:0]       RF_IN,
    output logic [(2**ADDR_W)-1:0]  PENDING_MASK
`ifdef REG_WB_STATS_EN
    ,
    output logic [15:0]             ALU_WR_CNT,
    output logic [15:0]             MEM_WR_CNT
`endif
);

    import reg_wb_pkg::*;

    localparam int unsigned WAIT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

    logic              alu_valid;
    logic [ADDR_W-1:0] alu_addr;
    logic [DATA_W-1:0] alu_data;
    logic              mem_valid;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;

    logic              grant_alu_c;
    logic              grant_mem_c;
    logic              alu_accept_c;
    logic              mem_accept_c;
    logic              mem_hold_c;
    wb_port_e          age_q;
    logic [WAIT_W-1:0] alu_wait_q;

    wb_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_alu_slot (
        .CLK      (CLK),
        .RESET    (RESET),
        .in_valid (ALU_VALID),
        .in_addr  (ALU_ADDR),
        .in_data  (ALU_DATA),
        .drain    (grant_alu_c),
        .ready_c  (ALU_READY),
        .valid    (alu_valid),
        .addr     (alu_addr),
        .data     (alu_data)
    );

    wb_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_mem_slot (
        .CLK      (CLK),
        .RESET    (RESET),
        .in_valid (MEM_VALID),
        .in_addr  (MEM_ADDR),
        .in_data  (MEM_DATA),
        .drain    (grant_mem_c),
        .ready_c  (MEM_READY),
        .valid    (mem_valid),
        .addr     (mem_addr),
        .data     (mem_data)
    );

    assign alu_accept_c = ALU_VALID && ALU_READY;
    assign mem_accept_c = MEM_VALID && MEM_READY;
    assign mem_hold_c   = mem_valid && !grant_mem_c;

    // Same-address pairs retire oldest-first; otherwise loads win until the ALU has waited too long.
    always_comb begin
        grant_alu_c = 1'b0;
        grant_mem_c = 1'b0;
        if (alu_valid && mem_valid) begin
            if (alu_addr == mem_addr) begin
                grant_alu_c = (age_q == WB_ALU);
                grant_mem_c = (age_q == WB_MEM);
            end else if (alu_wait_q == WAIT_W'(MAX_WAIT)) begin
                grant_alu_c = 1'b1;
            end else begin
                grant_mem_c = 1'b1;
            end
        end else begin
            grant_alu_c = alu_valid;
            grant_mem_c = mem_valid;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            RF_WRITE     <= 1'b0;
            RF_INADDRESS <= '0;
            RF_IN        <= '0;
            alu_wait_q   <= '0;
            age_q        <= WB_ALU;
        end else begin
            RF_WRITE <= grant_alu_c || grant_mem_c;
            if (grant_alu_c) begin
                RF_INADDRESS <= alu_addr;
                RF_IN        <= alu_data;
            end else if (grant_mem_c) begin
                RF_INADDRESS <= mem_addr;
                RF_IN        <= mem_data;
            end

            if (!alu_valid || grant_alu_c) begin
                alu_wait_q <= '0;
            end else if (alu_wait_q != WAIT_W'(MAX_WAIT)) begin
                alu_wait_q <= alu_wait_q + WAIT_W'(1);
            end

            // age_q names the slot holding the older entry; a same-edge double load favours the ALU.
            if (alu_accept_c && !mem_accept_c) begin
                age_q <= mem_hold_c ? WB_MEM : WB_ALU;
            end else if (mem_accept_c) begin
                age_q <= WB_ALU;
            end
        end
    end

    always_comb begin
        PENDING_MASK = '0;
        if (alu_valid) begin
            PENDING_MASK[alu_addr] = 1'b1;
        end
        if (mem_valid) begin
            PENDING_MASK[mem_addr] = 1'b1;
        end
        if (RF_WRITE) begin
            PENDING_MASK[RF_INADDRESS] = 1'b1;
        end
    end

`ifdef REG_WB_STATS_EN
    always_ff @(posedge CLK) begin
        if (RESET) begin
            ALU_WR_CNT <= '0;
            MEM_WR_CNT <= '0;
        end else begin
            if (grant_alu_c && (ALU_WR_CNT != 16'hFFFF)) begin
                ALU_WR_CNT <= ALU_WR_CNT + 16'd1;
            end
            if (grant_mem_c && (MEM_WR_CNT != 16'hFFFF)) begin
                MEM_WR_CNT <= MEM_WR_CNT + 16'd1;
            end
        end
    end
`endif

endmodule
